// File: rtl/flash_prog_pkg.sv
// Shared constants for the EPCS16 remote-programming command path.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the packet sync/ID bytes, command codes, reply type codes and the
// state encodings of the command parser and the reply arbiter.
package flash_prog_pkg;

    // Packet header bytes
    localparam logic [7:0] SYNC0_BYTE = 8'hEF;
    localparam logic [7:0] SYNC1_BYTE = 8'hFE;
    localparam logic [7:0] ID_BYTE    = 8'h03;

    // Command codes
    localparam logic [7:0] CMD_PROGRAM = 8'h01;
    localparam logic [7:0] CMD_ERASE   = 8'h02;

    // Reply types presented to the Tx packet builder
    localparam logic [1:0] REPLY_NONE       = 2'd0;
    localparam logic [1:0] REPLY_SEND_MORE  = 2'd1;
    localparam logic [1:0] REPLY_ERASE_DONE = 2'd2;

    // Command parser states
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SYNC1 = 4'd1;
    localparam logic [3:0] S_SYNC2 = 4'd2;
    localparam logic [3:0] S_CMD   = 4'd3;
    localparam logic [3:0] S_NB0   = 4'd4;
    localparam logic [3:0] S_NB1   = 4'd5;
    localparam logic [3:0] S_NB2   = 4'd6;
    localparam logic [3:0] S_NB3   = 4'd7;
    localparam logic [3:0] S_DATA  = 4'd8;
    localparam logic [3:0] S_DROP  = 4'd9;

    // Reply arbiter states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;

endpackage

// File: rtl/flash_reply_arb.sv
// Turns engine status flags into single-shot reply requests plus ACK pulses.
// Latency: request 1 cycle after flag seen; ACK pulse 1 cycle after tx_reply_ack.
// Backpressure: request held until tx_reply_ack; flags wait while a reply is open.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   erase_done, send_more     engine status flags (level)
//   tx_reply_req/_type        reply request and type to the Tx builder
//   tx_reply_ack              Tx builder has queued the reply
//   erase_done_ACK, send_more_ACK  one-cycle pulses back to the engine
module flash_reply_arb
    import flash_prog_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       erase_done,
    input  logic       send_more,
    input  logic       tx_reply_ack,
    output logic       tx_reply_req,
    output logic [1:0] tx_reply_type,
    output logic       erase_done_ACK,
    output logic       send_more_ACK
);

    logic [1:0] r_state;
    logic       r_req;
    logic [1:0] r_type;
    logic       r_ed_ack;
    logic       r_sm_ack;
    // A serviced flag is masked until the engine drops it, so a flag that
    // stays high never produces a second reply.
    logic       r_ed_mask;
    logic       r_sm_mask;

    logic w_ed_pend;
    logic w_sm_pend;
    logic w_srv_flag;
    logic w_other_pend;

    assign w_ed_pend    = erase_done && !r_ed_mask;
    assign w_sm_pend    = send_more  && !r_sm_mask;
    assign w_srv_flag   = (r_type == REPLY_ERASE_DONE) ? erase_done : send_more;
    assign w_other_pend = (r_type == REPLY_ERASE_DONE) ? w_sm_pend  : w_ed_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_req     <= 1'b0;
            r_type    <= REPLY_NONE;
            r_ed_ack  <= 1'b0;
            r_sm_ack  <= 1'b0;
            r_ed_mask <= 1'b0;
            r_sm_mask <= 1'b0;
        end else begin
            r_ed_ack <= 1'b0;
            r_sm_ack <= 1'b0;
            if (!erase_done) r_ed_mask <= 1'b0;
            if (!send_more)  r_sm_mask <= 1'b0;

            case (r_state)
                R_IDLE: begin
                    if (w_ed_pend) begin
                        r_type  <= REPLY_ERASE_DONE;
                        r_req   <= 1'b1;
                        r_state <= R_REQ;
                    end else if (w_sm_pend) begin
                        r_type  <= REPLY_SEND_MORE;
                        r_req   <= 1'b1;
                        r_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (tx_reply_ack) begin
                        r_req <= 1'b0;
                        if (r_type == REPLY_ERASE_DONE) begin
                            r_ed_ack  <= 1'b1;
                            r_ed_mask <= 1'b1;
                        end else begin
                            r_sm_ack  <= 1'b1;
                            r_sm_mask <= 1'b1;
                        end
                        r_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    // Leave once the engine clears the serviced flag, or early
                    // if the other flag is waiting (the mask still blocks repeats).
                    if (!w_srv_flag || w_other_pend) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign tx_reply_req   = r_req;
    assign tx_reply_type  = r_type;
    assign erase_done_ACK = r_ed_ack;
    assign send_more_ACK  = r_sm_ack;

endmodule

// File: rtl/flash_prog_rx.sv
// Parses programming UDP payloads into Rx FIFO page writes, erase request and block count.
// Latency: FIFO write, erase and num_blocks appear 1 cycle after the deciding byte.
// Backpressure: none on Rx; fifo_full mid-page drops the rest of the packet and flags prog_error.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   rx_data/rx_valid/rx_sop      payload byte stream from the Ethernet Rx path
//   fifo_data/fifo_wrreq         registered byte write into the Rx FIFO; fifo_full in
//   erase/erase_ACK              erase request held until the engine acknowledges
//   num_blocks                   total 256-byte pages of the image
//   erase_done/send_more + ACKs  engine status flags and their acknowledge pulses
//   tx_reply_req/_type/_ack      reply request handshake with the Tx packet builder
//   prog_error                   sticky error, cleared by reset or an accepted erase
module flash_prog_rx
    import flash_prog_pkg::*;
#(
    parameter int PAGE_BYTES = 256,
    parameter int NB_WIDTH   = 14
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                rx_sop,
    output logic [7:0]          fifo_data,
    output logic                fifo_wrreq,
    input  logic                fifo_full,
    output logic                erase,
    input  logic                erase_ACK,
    output logic [NB_WIDTH-1:0] num_blocks,
    input  logic                erase_done,
    input  logic                send_more,
    output logic                erase_done_ACK,
    output logic                send_more_ACK,
    output logic                tx_reply_req,
    output logic [1:0]          tx_reply_type,
    input  logic                tx_reply_ack,
    output logic                prog_error
);

    localparam int            CW        = $clog2(PAGE_BYTES);
    localparam logic [CW-1:0] PAGE_LAST = CW'(PAGE_BYTES - 1);

    logic [3:0]          r_state;
    logic [23:0]         r_count;       // first three block-count bytes, MSB first
    logic [CW-1:0]       r_byte_cnt;
    logic [7:0]          r_fifo_data;
    logic                r_fifo_wrreq;
    logic                r_erase;
    logic                r_prog_error;
    logic [NB_WIDTH-1:0] r_num_blocks;

    logic [31:0] w_count;
    logic        w_count_ok;

    // Full count is formed on the last count byte so it can be checked and
    // registered in the same cycle.
    assign w_count    = {r_count, rx_data};
    assign w_count_ok = (w_count[31:NB_WIDTH] == '0) && (w_count != 32'd0) && !r_erase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_byte_cnt   <= '0;
            r_fifo_data  <= '0;
            r_fifo_wrreq <= 1'b0;
            r_erase      <= 1'b0;
            r_prog_error <= 1'b0;
            r_num_blocks <= '0;
        end else begin
            r_fifo_wrreq <= 1'b0;

            // Erase can only be set while low, so this never collides with a set.
            if (erase_ACK && r_erase) r_erase <= 1'b0;

            if (rx_valid) begin
                if (rx_sop) begin
                    // A new payload interrupting a page leaves a partial page in
                    // the FIFO; the host recovers by re-erasing.
                    if (r_state == S_DATA) r_prog_error <= 1'b1;
                    r_state <= (rx_data == SYNC0_BYTE) ? S_SYNC1 : S_DROP;
                end else begin
                    case (r_state)
                        S_IDLE:  r_state <= S_DROP;
                        S_SYNC1: r_state <= (rx_data == SYNC1_BYTE) ? S_SYNC2 : S_DROP;
                        S_SYNC2: r_state <= (rx_data == ID_BYTE)    ? S_CMD   : S_DROP;
                        S_CMD: begin
                            if (rx_data == CMD_ERASE) begin
                                // A repeat erase while one is pending is ignored.
                                if (!r_erase) begin
                                    r_erase      <= 1'b1;
                                    r_prog_error <= 1'b0;
                                end
                                r_state <= S_IDLE;
                            end else if (rx_data == CMD_PROGRAM) begin
                                r_state <= S_NB0;
                            end else begin
                                r_state <= S_DROP;
                            end
                        end
                        S_NB0, S_NB1, S_NB2: begin
                            r_count <= {r_count[15:0], rx_data};
                            r_state <= r_state + 4'd1;
                        end
                        S_NB3: begin
                            if (w_count_ok) begin
                                r_num_blocks <= w_count[NB_WIDTH-1:0];
                                r_byte_cnt   <= '0;
                                r_state      <= S_DATA;
                            end else begin
                                r_prog_error <= 1'b1;
                                r_state      <= S_DROP;
                            end
                        end
                        S_DATA: begin
                            if (fifo_full) begin
                                r_prog_error <= 1'b1;
                                r_state      <= S_DROP;
                            end else begin
                                r_fifo_wrreq <= 1'b1;
                                r_fifo_data  <= rx_data;
                                r_byte_cnt   <= r_byte_cnt + CW'(1);
                                // Trailing bytes after a full page fall into DROP via IDLE.
                                if (r_byte_cnt == PAGE_LAST) r_state <= S_IDLE;
                            end
                        end
                        S_DROP:  r_state <= S_DROP;
                        default: r_state <= S_DROP;
                    endcase
                end
            end
        end
    end

    assign fifo_data  = r_fifo_data;
    assign fifo_wrreq = r_fifo_wrreq;
    assign erase      = r_erase;
    assign num_blocks = r_num_blocks;
    assign prog_error = r_prog_error;

    flash_reply_arb u_reply_arb (
        .clock          (clock),
        .reset          (reset),
        .erase_done     (erase_done),
        .send_more      (send_more),
        .tx_reply_ack   (tx_reply_ack),
        .tx_reply_req   (tx_reply_req),
        .tx_reply_type  (tx_reply_type),
        .erase_done_ACK (erase_done_ACK),
        .send_more_ACK  (send_more_ACK)
    );

endmodule

// File: tb/tb_flash_prog_rx.sv
// Self-checking bench for flash_prog_rx: packet-position reference model,
// per-cycle output compare, directed scenarios and randomized packet traffic.
module tb_flash_prog_rx;

    localparam int PB  = 256;
    localparam int NBW = 14;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic           rx_sop = 1'b0;
    logic [7:0]     fifo_data;
    logic           fifo_wrreq;
    logic           fifo_full = 1'b0;
    logic           erase;
    logic           erase_ACK = 1'b0;
    logic [NBW-1:0] num_blocks;
    logic           erase_done = 1'b0;
    logic           send_more = 1'b0;
    logic           erase_done_ACK;
    logic           send_more_ACK;
    logic           tx_reply_req;
    logic [1:0]     tx_reply_type;
    logic           tx_reply_ack = 1'b0;
    logic           prog_error;

    flash_prog_rx #(.PAGE_BYTES(PB), .NB_WIDTH(NBW)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sop(rx_sop), .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq),
        .fifo_full(fifo_full), .erase(erase), .erase_ACK(erase_ACK),
        .num_blocks(num_blocks), .erase_done(erase_done), .send_more(send_more),
        .erase_done_ACK(erase_done_ACK), .send_more_ACK(send_more_ACK),
        .tx_reply_req(tx_reply_req), .tx_reply_type(tx_reply_type),
        .tx_reply_ack(tx_reply_ack), .prog_error(prog_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rnd_mode = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet position based) ----------------
    bit             m_alive = 1'b0;   // current packet still being honoured
    bit             m_in_page = 1'b0; // page data expected but not yet complete
    int             m_pos = 0;        // byte index within the packet, 0 = sop byte
    logic [31:0]    m_count = '0;
    logic           m_wr = 1'b0;
    logic [7:0]     m_data = '0;
    logic           m_erase = 1'b0;
    logic           m_err = 1'b0;
    logic [NBW-1:0] m_nb = '0;

    task automatic model_step();
        logic old_erase;
        if (reset) begin
            m_alive = 0; m_in_page = 0; m_pos = 0; m_wr = 0;
            m_erase = 0; m_err = 0; m_nb = '0; m_data = '0;
            return;
        end
        old_erase = m_erase;
        m_wr = 0;
        if (erase_ACK && old_erase) m_erase = 0;
        if (!rx_valid) return;
        if (rx_sop) begin
            if (m_in_page) m_err = 1;
            m_in_page = 0;
            m_pos = 0;
            m_alive = (rx_data == 8'hEF);
        end else if (m_alive) begin
            m_pos++;
            if (m_pos == 1) m_alive = (rx_data == 8'hFE);
            else if (m_pos == 2) m_alive = (rx_data == 8'h03);
            else if (m_pos == 3) begin
                if (rx_data == 8'h02) begin
                    if (!old_erase) begin m_erase = 1; m_err = 0; end
                    m_alive = 0;
                end else if (rx_data != 8'h01) m_alive = 0;
            end else if (m_pos <= 7) begin
                m_count = {m_count[23:0], rx_data};
                if (m_pos == 7) begin
                    if (m_count == 0 || m_count >= (32'd1 << NBW) || old_erase) begin
                        m_err = 1; m_alive = 0;
                    end else begin
                        m_nb = m_count[NBW-1:0];
                        m_in_page = 1;
                    end
                end
            end else begin
                if (fifo_full) begin
                    m_err = 1; m_alive = 0; m_in_page = 0;
                end else begin
                    m_wr = 1; m_data = rx_data;
                    if (m_pos == 7 + PB) begin m_alive = 0; m_in_page = 0; end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            check("wrreq", {31'd0, fifo_wrreq}, {31'd0, m_wr});
            if (m_wr) check("fifo_data", {24'd0, fifo_data}, {24'd0, m_data});
            check("erase", {31'd0, erase}, {31'd0, m_erase});
            check("num_blocks", 32'(num_blocks), 32'(m_nb));
            check("prog_error", {31'd0, prog_error}, {31'd0, m_err});
        end
    end

    // ---------------- DUT observation ----------------
    int   wr_cnt = 0;
    int   ed_pulses = 0;
    int   sm_pulses = 0;
    logic [7:0] wr_q[$];

    initial forever begin
        @(negedge clock);
        if (fifo_wrreq === 1'b1) begin wr_cnt++; wr_q.push_back(fifo_data); end
        if (erase_done_ACK === 1'b1) ed_pulses++;
        if (send_more_ACK === 1'b1) sm_pulses++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rx_valid = 0; rx_sop = 0; rx_data = 8'($urandom);
            fifo_full = rnd_mode ? ($urandom_range(0, 149) == 0) : 1'b0;
            if (rnd_mode) erase_ACK = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit sop, input bit full);
        if (rnd_mode && $urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
        @(negedge clock);
        rx_valid = 1; rx_data = b; rx_sop = sop;
        fifo_full = rnd_mode ? ($urandom_range(0, 149) == 0) : full;
        if (rnd_mode) erase_ACK = ($urandom_range(0, 7) == 0);
    endtask

    task automatic send_hdr(input logic [7:0] cmd);
        send_byte(8'hEF, 1, 0);
        send_byte(8'hFE, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(cmd, 0, 0);
    endtask

    task automatic send_prog(input logic [31:0] cnt, input int len, input bit ramp, input int full_at);
        send_hdr(8'h01);
        for (int i = 0; i < 4; i++) send_byte(cnt[31 - 8*i -: 8], 0, 0);
        for (int i = 0; i < len; i++)
            send_byte(ramp ? 8'(i) : 8'($urandom), 0, (full_at >= 0) && (i >= full_at));
    endtask

    task automatic erase_and_ack();
        send_hdr(8'h02);
        idle(1);
        @(negedge clock) erase_ACK = 1;
        @(negedge clock) erase_ACK = 0;
        idle(1);
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_reply_req === 1'b1) begin ok = 1; break; end
            @(negedge clock);
        end
    endtask

    task automatic rnd_packet();
        int k;
        int r;
        int len;
        logic [31:0] cnt;
        k = $urandom_range(0, 9);
        if (k <= 1) begin
            send_hdr(8'h02);
        end else if (k <= 6) begin
            r = $urandom_range(0, 9);
            if (r == 0) cnt = 32'd0;
            else if (r == 1) cnt = 32'd1 << $urandom_range(NBW, 31);
            else cnt = 32'($urandom_range(1, (1 << NBW) - 1));
            r = $urandom_range(0, 7);
            if (r == 0) len = $urandom_range(0, PB - 1);
            else if (r == 1) len = PB + $urandom_range(1, 5);
            else len = PB;
            send_prog(cnt, len, 0, -1);
        end else if (k <= 8) begin
            send_byte(($urandom_range(0, 1) == 1) ? 8'hEF : 8'($urandom), 1, 0);
            repeat ($urandom_range(3, 6)) begin
                r = $urandom_range(0, 5);
                case (r)
                    0: send_byte(8'hEF, 0, 0);
                    1: send_byte(8'hFE, 0, 0);
                    2: send_byte(8'h03, 0, 0);
                    3: send_byte(8'h01, 0, 0);
                    4: send_byte(8'h02, 0, 0);
                    default: send_byte(8'($urandom), 0, 0);
                endcase
            end
        end else begin
            repeat (3) send_byte(8'($urandom), 0, 0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int bad;

        repeat (3) @(negedge clock);
        reset = 0;
        cmp_en = 1;
        @(negedge clock);
        check("rst_fifo_wrreq", {31'd0, fifo_wrreq}, 32'd0);
        check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
        check("rst_erase", {31'd0, erase}, 32'd0);
        check("rst_num_blocks", 32'(num_blocks), 32'd0);
        check("rst_prog_error", {31'd0, prog_error}, 32'd0);
        check("rst_reply", {28'd0, tx_reply_req, tx_reply_type, erase_done_ACK}, 32'd0);
        check("rst_sm_ack", {31'd0, send_more_ACK}, 32'd0);

        // Erase: rises one cycle after the command byte, repeat ignored, ACK clears.
        send_hdr(8'h02);
        idle(1);
        check("erase_set", {31'd0, erase}, 32'd1);
        send_hdr(8'h02);
        idle(1);
        check("erase_still", {31'd0, erase}, 32'd1);
        @(negedge clock) erase_ACK = 1;
        @(negedge clock) erase_ACK = 0;
        check("erase_cleared", {31'd0, erase}, 32'd0);

        // Full page ramp plus one trailing byte that must be ignored.
        idle(2);
        wr_cnt = 0; wr_q.delete();
        send_prog(32'h40, PB + 1, 1, -1);
        idle(3);
        check("ramp_num_blocks", 32'(num_blocks), 32'd64);
        check("ramp_writes", 32'(wr_cnt), 32'd256);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== 8'(i)) bad++;
        check("ramp_data_bad", 32'(bad), 32'd0);

        // Oversized and zero counts are rejected; erase clears the error.
        wr_cnt = 0;
        send_prog(32'h0001_0000, 8, 1, -1);
        idle(2);
        check("big_cnt_writes", 32'(wr_cnt), 32'd0);
        check("big_cnt_err", {31'd0, prog_error}, 32'd1);
        send_hdr(8'h02);
        idle(1);
        check("erase_clr_err", {31'd0, prog_error}, 32'd0);
        @(negedge clock) erase_ACK = 1;
        @(negedge clock) erase_ACK = 0;
        send_prog(32'h0, 8, 1, -1);
        idle(2);
        check("zero_cnt_writes", 32'(wr_cnt), 32'd0);
        check("zero_cnt_err", {31'd0, prog_error}, 32'd1);
        erase_and_ack();

        // FIFO full at data byte 100.
        wr_cnt = 0;
        send_prog(32'd1, PB, 1, 100);
        idle(2);
        check("full_writes", 32'(wr_cnt), 32'd100);
        check("full_err", {31'd0, prog_error}, 32'd1);
        erase_and_ack();

        // New packet after 50 data bytes.
        wr_cnt = 0;
        send_prog(32'd2, 50, 1, -1);
        send_prog(32'd5, PB, 1, -1);
        idle(2);
        check("sop_err", {31'd0, prog_error}, 32'd1);
        check("sop_writes", 32'(wr_cnt), 32'd306);
        check("sop_num_blocks", 32'(num_blocks), 32'd5);

        // Reset mid-packet: trailing bytes are dropped.
        erase_and_ack();
        send_prog(32'd9, 20, 1, -1);
        @(negedge clock) begin rx_valid = 0; reset = 1; end
        @(negedge clock) reset = 0;
        check("midrst_num_blocks", 32'(num_blocks), 32'd0);
        wr_cnt = 0;
        for (int i = 0; i < 30; i++) send_byte(8'(i), 0, 0);
        idle(2);
        check("midrst_writes", 32'(wr_cnt), 32'd0);

        // Reply arbiter: both flags together, erase-done first.
        ed_pulses = 0; sm_pulses = 0;
        @(negedge clock) begin erase_done = 1; send_more = 1; end
        @(negedge clock);
        check("req_latency", {31'd0, tx_reply_req}, 32'd1);
        check("type_first", {30'd0, tx_reply_type}, 32'd2);
        repeat (3) @(negedge clock);
        check("type_hold", {30'd0, tx_reply_type}, 32'd2);
        tx_reply_ack = 1;
        @(negedge clock) tx_reply_ack = 0;
        check("ed_ack_pulse", {31'd0, erase_done_ACK}, 32'd1);
        check("req_drop", {31'd0, tx_reply_req}, 32'd0);
        @(negedge clock);
        check("ed_ack_end", {31'd0, erase_done_ACK}, 32'd0);
        wait_req(ok);
        check("req_second", {31'd0, ok}, 32'd1);
        check("type_second", {30'd0, tx_reply_type}, 32'd1);
        repeat (3) @(negedge clock);
        tx_reply_ack = 1;
        @(negedge clock) tx_reply_ack = 0;
        check("sm_ack_pulse", {31'd0, send_more_ACK}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("no_repeat_req", {31'd0, tx_reply_req}, 32'd0);
        end
        check("ed_pulse_count", 32'(ed_pulses), 32'd1);
        check("sm_pulse_count", 32'(sm_pulses), 32'd1);
        @(negedge clock) begin erase_done = 0; send_more = 0; end
        idle(3);

        // Randomized traffic against the model.
        rnd_mode = 1;
        repeat (60) rnd_packet();
        rnd_mode = 0;
        erase_ACK = 0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_prog_rx.md
# flash_prog_rx

Upstream command stage for the EPCS16 remote-programming path. Parses the byte stream of programming UDP payloads from the Ethernet Rx path and writes page data into the Rx FIFO that feeds the ASMI programming engine. Raises the erase request and latches the total block count. Arbitrates the engine's `erase_done` and `send_more` status flags into single-shot reply requests to the Tx packet builder, and returns the matching ACKs to the engine.

## Interface
Parameters:
- `PAGE_BYTES`, default 256: payload bytes per program packet.
- `NB_WIDTH`, default 14: width of `num_blocks`.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  UDP payload byte.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_sop`  in  1  qualifies the first byte of a payload; valid only with `rx_valid`.
- `fifo_data`  out  8  byte to the Rx FIFO, registered.
- `fifo_wrreq`  out  1  FIFO write strobe, one cycle per byte.
- `fifo_full`  in  1  Rx FIFO full.
- `erase`  out  1  erase request; held high until `erase_ACK`.
- `erase_ACK`  in  1  engine has seen the erase request.
- `num_blocks`  out  NB_WIDTH  total 256-byte pages in the image.
- `erase_done`  in  1  engine status flag.
- `send_more`  in  1  engine status flag.
- `erase_done_ACK`  out  1  one-cycle pulse.
- `send_more_ACK`  out  1  one-cycle pulse.
- `tx_reply_req`  out  1  request to Tx to send a reply packet.
- `tx_reply_type`  out  2  1 = send-more, 2 = erase-done; stable while `tx_reply_req` is high.
- `tx_reply_ack`  in  1  Tx has queued the reply.
- `prog_error`  out  1  sticky error flag; cleared by reset or by an accepted erase command.

Reset values: every output is 0. The reply type output is also 0.

## Operation
Packet format is big-endian:
- Sync bytes `EF FE`, then `03`, then a command byte.
- Command 0x02 (erase): no further bytes.
- Command 0x01 (program): a 4-byte block count, then `PAGE_BYTES` data bytes.

Parser FSM. It advances one state per byte with `rx_valid`.
- `IDLE`: expects `EF` with `rx_sop`.
- `SYNC1`: expects `FE`.
- `SYNC2`: expects `03`.
- `CMD`: dispatches on the command byte.
- `NB0`..`NB3`: collect the block count.
- `DATA`: forwards payload bytes.
- `DROP`: discards bytes.

Transitions and rules:
- Any mismatched header byte, or an unknown command, goes to `DROP`.
- `DROP` ends only at the next `rx_sop`.
- `rx_sop` in any state restarts at `SYNC1` if the byte is `EF`, and at `DROP` otherwise.
- Erase command:
  - If `erase` is not already pending: set `erase`, clear `prog_error`, go to `IDLE`.
  - If `erase` is already pending: ignore the command.
- Block count:
  - Reject with `prog_error` and `DROP` if the upper 32−NB_WIDTH bits are non-zero, if the count is zero, or if `erase` is still pending.
  - Otherwise register the count into `num_blocks` on the `NB3` byte.
- `DATA` behaviour:
  - Each byte produces one `fifo_wrreq` with `fifo_data`.
  - An 8-bit counter runs from 0 to 255. The state returns to `IDLE` after byte 255.
  - Bytes after 255 within the same packet are ignored.
- `fifo_full` while a data byte is presented: the byte is not written, `prog_error` is set, and the FSM goes to `DROP`.
- A new `rx_sop` before the page completes: set `prog_error`. Bytes already written stay in the FIFO; the host recovers by re-erasing.
- `erase` clears on the cycle after `erase_ACK`. `erase_ACK` while `erase` is low is ignored.

Reply arbiter FSM:
- States: `R_IDLE`, `R_REQ`, `R_ACK`.
- `R_IDLE`:
  - If `erase_done` is high: type 2 (erase-done has priority).
  - Else if `send_more` is high: type 1.
  - On either, go to `R_REQ` with `tx_reply_req` = 1.
- `R_REQ`: hold until `tx_reply_ack`, then pulse the matching ACK for one cycle and go to `R_ACK`.
- `R_ACK`: wait until the serviced flag is low, then return to `R_IDLE`. This prevents a double reply while the engine clears its flag.
- If both flags are high together, both are serviced sequentially, erase-done first.

## Timing
- `fifo_wrreq`/`fifo_data` are asserted the cycle after the accepted `rx_valid` byte.
- `erase` rises the cycle after the `CMD` byte.
- `num_blocks` is valid the cycle after the `NB3` byte, before the first data write.
- Reply latency:
  - `tx_reply_req` rises one cycle after the flag is seen high.
  - The ACK pulse occurs one cycle after `tx_reply_ack`.
- `reset` mid-packet: returns to `IDLE`, clears `erase`, outputs and `num_blocks`. The following bytes are dropped until the next `rx_sop`.
- Back-to-back `rx_valid` is supported every cycle. There is no backpressure on the Rx side.

## Structure
- Package `flash_prog_pkg`:
  - sync/ID byte constants (`EF`, `FE`, `03`);
  - command codes `CMD_PROGRAM` = 1, `CMD_ERASE` = 2;
  - reply type codes;
  - parser and arbiter state encodings.
- Sub-module `flash_reply_arb`: contains the reply arbiter FSM and the ACK pulse generation.
- The parser lives in the top module.

## Test plan
- Send `EF FE 03 02` → `erase` = 1 one cycle later. Assert `erase_ACK` → `erase` = 0 next cycle. A second erase sent while pending leaves `erase` unchanged.
- Send a program packet with count 0x00000040 and a 256-byte ramp 0x00..0xFF → `num_blocks` = 64, exactly 256 `fifo_wrreq` pulses with data 0x00..0xFF, parser back in `IDLE`.
- Send a count of 0x00010000 or 0 → no writes, `prog_error` = 1. A subsequent erase clears `prog_error`.
- Raise `fifo_full` at data byte 100 → 100 writes only, `prog_error` = 1, rest of the packet dropped.
- Send a new `rx_sop` with `EF` after 50 data bytes → `prog_error` = 1, new packet parsed normally.
- Raise `erase_done` and `send_more` together, ack each `tx_reply_req` after 3 cycles → type 2 then type 1. One `erase_done_ACK` pulse and one `send_more_ACK` pulse. No repeat while the flags stay high for 5 more cycles.
